neopix_rx: RTL and testbench

- WS2812 ("NeoPixel") single-wire bitstream decoder: the receive end of the pixel strip output that spi_to_neopix drives.
- Samples one DO line, classifies high-pulse widths as 0/1 bits and assembles 24-bit pixel words, MSB first, in wire order.
- Reports pixel index, frame end (latch/reset gap) and protocol errors.
- Used in loopback self-test of strip outputs and as a bench monitor; sits beside spi_to_neopix in the top level on the same system clock.

---
 rtl/neopix_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_neopix_rx.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neopix_rx.sv
// neopix_rx -- WS2812 ("NeoPixel") single-wire bitstream decoder.
//
// Samples the strip data line, measures each high pulse and turns it into a
// 0 or 1 bit, assembles 24-bit pixel words MSB first in wire order, and
// reports pixel index, frame end (latch gap) and protocol errors.
//
// Ports:
//   clk_i         system clock (SYSTEM_CLOCK Hz)
//   reset_ni      asynchronous reset, active low; clears all state
//   din_i         WS2812 serial data, asynchronous to clk_i
//   pix_data_o    last completed pixel, bit 23 = first bit received
//   pix_idx_o     index of pix_data_o within the current frame (0-based)
//   pix_valid_o   one-cycle strobe, pix_data_o/pix_idx_o valid this cycle
//   frame_done_o  one-cycle strobe at latch detection
//   frame_len_o   complete pixels in the frame just ended (with frame_done_o)
//   err_o         one-cycle strobe on any protocol error
//   busy_o        high from the first recorded bit until the latch gap
//
// Strobe semantics: pix_valid_o, frame_done_o and err_o are single-cycle
// pulses with no back-pressure; a consumer must sample them every cycle.
// pix_data_o and frame_len_o hold their value until the next update.

module neopix_rx #(
    parameter int SYSTEM_CLOCK = 50000000,
    parameter int NUM_LEDS     = 256,
    parameter int T_BIT1_NS    = 600,
    parameter int T_MIN_NS     = 150,
    parameter int T_MAX_NS     = 2000,
    parameter int T_RESET_NS   = 50000,
    localparam int IDX_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             din_i,
    output logic [23:0]      pix_data_o,
    output logic [IDX_W-1:0] pix_idx_o,
    output logic             pix_valid_o,
    output logic             frame_done_o,
    output logic [IDX_W:0]   frame_len_o,
    output logic             err_o,
    output logic             busy_o
);

    // Cycle thresholds derived from the nanosecond timings.
    localparam int CLK_MHZ   = SYSTEM_CLOCK / 1000000;
    localparam int BIT1_CYC  = CLK_MHZ * T_BIT1_NS / 1000;
    localparam int MIN_CYC   = CLK_MHZ * T_MIN_NS / 1000;
    localparam int MAX_CYC   = CLK_MHZ * T_MAX_NS / 1000;
    localparam int RESET_CYC = CLK_MHZ * T_RESET_NS / 1000;
    localparam int CNT_TOP   = (RESET_CYC > MAX_CYC) ? RESET_CYC : MAX_CYC;
    localparam int CNT_W     = $clog2(CNT_TOP + 1);

    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT1_C     = CNT_W'(BIT1_CYC);
    localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_CYC);
    // The compare is made on the cycle that would bring the count to RESET_CYC.
    localparam logic [CNT_W-1:0] RST_LAST_C = CNT_W'(RESET_CYC - 1);
    localparam logic [IDX_W:0]   PIX_MAX_C  = (IDX_W + 1)'(NUM_LEDS);
    localparam logic [IDX_W:0]   PIX_ONE_C  = (IDX_W + 1)'(1);

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_IDLE = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_t;

    state_t           state_q;
    logic             sync1_q;
    logic             line_q;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] lcnt_q;
    logic [22:0]      shift_q;
    logic [4:0]       bitcnt_q;
    logic [IDX_W:0]   pixcnt_q;
    logic             busy_q;
    logic [23:0]      pix_data_q;
    logic [IDX_W-1:0] pix_idx_q;
    logic             pix_valid_q;
    logic             frame_done_q;
    logic [IDX_W:0]   frame_len_q;
    logic             err_q;

    // Bit decoded from the pulse that is ending, and the word it completes.
    logic             hi_bit;
    logic [23:0]      word_d;
    logic [CNT_W-1:0] lcnt_inc;

    assign hi_bit   = (hcnt_q >= BIT1_C);
    assign word_d   = {shift_q, hi_bit};
    assign lcnt_inc = (lcnt_q == '1) ? lcnt_q : lcnt_q + ONE_C;

    // Two-flop synchronizer for the asynchronous data line.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1_q <= 1'b0;
            line_q  <= 1'b0;
        end else begin
            sync1_q <= din_i;
            line_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_SYNC;
            hcnt_q       <= '0;
            lcnt_q       <= '0;
            shift_q      <= '0;
            bitcnt_q     <= '0;
            pixcnt_q     <= '0;
            busy_q       <= 1'b0;
            pix_data_q   <= '0;
            pix_idx_q    <= '0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;

            case (state_q)
                // Wait for a full latch-length low so decoding never starts
                // in the middle of a frame.
                S_SYNC: begin
                    if (line_q) begin
                        lcnt_q <= '0;
                    end else begin
                        lcnt_q <= lcnt_inc;
                        if (lcnt_q == RST_LAST_C) begin
                            state_q <= S_IDLE;
                        end
                    end
                end

                S_IDLE: begin
                    if (line_q) begin
                        hcnt_q  <= ONE_C;
                        state_q <= S_HIGH;
                    end
                end

                S_HIGH: begin
                    if (line_q) begin
                        if (hcnt_q >= MAX_C) begin
                            // Over-long pulse: drop the frame and resynchronize.
                            err_q    <= 1'b1;
                            shift_q  <= '0;
                            bitcnt_q <= '0;
                            pixcnt_q <= '0;
                            busy_q   <= 1'b0;
                            lcnt_q   <= '0;
                            state_q  <= S_SYNC;
                        end else begin
                            hcnt_q <= hcnt_q + ONE_C;
                        end
                    end else begin
                        lcnt_q  <= ONE_C;
                        state_q <= S_LOW;
                        if (hcnt_q < MIN_C) begin
                            // Glitch: flagged but the frame carries on.
                            err_q <= 1'b1;
                        end else begin
                            busy_q <= 1'b1;
                            if (bitcnt_q == 5'd23) begin
                                bitcnt_q <= '0;
                                shift_q  <= '0;
                                if (pixcnt_q == PIX_MAX_C) begin
                                    // Pixel beyond NUM_LEDS is dropped.
                                    err_q <= 1'b1;
                                end else begin
                                    pix_valid_q <= 1'b1;
                                    pix_data_q  <= word_d;
                                    pix_idx_q   <= pixcnt_q[IDX_W-1:0];
                                    pixcnt_q    <= pixcnt_q + PIX_ONE_C;
                                end
                            end else begin
                                bitcnt_q <= bitcnt_q + 5'd1;
                                shift_q  <= word_d[22:0];
                            end
                        end
                    end
                end

                S_LOW: begin
                    if (line_q) begin
                        hcnt_q  <= ONE_C;
                        state_q <= S_HIGH;
                    end else begin
                        lcnt_q <= lcnt_inc;
                        if (lcnt_q == RST_LAST_C) begin
                            if (busy_q) begin
                                frame_done_q <= 1'b1;
                                frame_len_q  <= pixcnt_q;
                            end
                            if (bitcnt_q != 5'd0) begin
                                err_q <= 1'b1;
                            end
                            shift_q  <= '0;
                            bitcnt_q <= '0;
                            pixcnt_q <= '0;
                            busy_q   <= 1'b0;
                            state_q  <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= S_SYNC;
                    lcnt_q  <= '0;
                end
            endcase
        end
    end

    assign pix_data_o   = pix_data_q;
    assign pix_idx_o    = pix_idx_q;
    assign pix_valid_o  = pix_valid_q;
    assign frame_done_o = frame_done_q;
    assign frame_len_o  = frame_len_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_neopix_rx.sv
// tb_neopix_rx -- directed bench for neopix_rx at 50 MHz.
// Two instances share the data line: u_dut with default NUM_LEDS and u_dut4
// with NUM_LEDS=4 for the pixel overflow case.

module tb_neopix_rx;

    logic clk_i = 1'b0;
    always #10 clk_i = ~clk_i;

    logic        reset_ni;
    logic        din_i;

    logic [23:0] pix_data;
    logic [7:0]  pix_idx;
    logic        pix_valid;
    logic        frame_done;
    logic [8:0]  frame_len;
    logic        err;
    logic        busy;

    logic [23:0] pix_data4;
    logic [1:0]  pix_idx4;
    logic        pix_valid4;
    logic        frame_done4;
    logic [2:0]  frame_len4;
    logic        err4;
    logic        busy4;

    neopix_rx u_dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .din_i        (din_i),
        .pix_data_o   (pix_data),
        .pix_idx_o    (pix_idx),
        .pix_valid_o  (pix_valid),
        .frame_done_o (frame_done),
        .frame_len_o  (frame_len),
        .err_o        (err),
        .busy_o       (busy)
    );

    neopix_rx #(.NUM_LEDS(4)) u_dut4 (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .din_i        (din_i),
        .pix_data_o   (pix_data4),
        .pix_idx_o    (pix_idx4),
        .pix_valid_o  (pix_valid4),
        .frame_done_o (frame_done4),
        .frame_len_o  (frame_len4),
        .err_o        (err4),
        .busy_o       (busy4)
    );

    // ---------------- monitor (only writer of the tallies) ----------------
    int          n_pv = 0, n_fd = 0, n_err = 0, n_both = 0, n_clash = 0;
    int          n_pv4 = 0, n_fd4 = 0, n_err4 = 0, n_clash4 = 0;
    logic [8:0]  last_len = '0;
    logic [2:0]  last_len4 = '0;
    logic [31:0] got_pix [64];
    logic [31:0] got_pix4 [64];

    always @(negedge clk_i) begin
        if (pix_valid) begin
            got_pix[n_pv % 64] = {pix_idx, pix_data};
            n_pv++;
        end
        if (frame_done) begin
            n_fd++;
            last_len = frame_len;
        end
        if (err) n_err++;
        if (err && frame_done) n_both++;
        if (err && pix_valid) n_clash++;

        if (pix_valid4) begin
            got_pix4[n_pv4 % 64] = {6'd0, pix_idx4, pix_data4};
            n_pv4++;
        end
        if (frame_done4) begin
            n_fd4++;
            last_len4 = frame_len4;
        end
        if (err4) n_err4++;
        if (err4 && pix_valid4) n_clash4++;
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] exp4_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int b_pv, b_fd, b_err, b_both, b_pv4, b_fd4, b_err4;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_pv  = n_pv;  b_fd  = n_fd;  b_err  = n_err;  b_both = n_both;
        b_pv4 = n_pv4; b_fd4 = n_fd4; b_err4 = n_err4;
    endtask

    // Compare every pixel captured since the last snap against exp_q/exp4_q.
    task automatic score(input string tag);
        int n;
        logic [31:0] w;
        n = exp_q.size();
        check_val({tag, "_pv_cnt"}, n_pv - b_pv, n);
        for (int i = 0; i < n; i++) begin
            w = exp_q.pop_front();
            check_val({tag, "_pix"}, got_pix[(b_pv + i) % 64], w);
        end
        n = exp4_q.size();
        check_val({tag, "_pv_cnt4"}, n_pv4 - b_pv4, n);
        for (int i = 0; i < n; i++) begin
            w = exp4_q.pop_front();
            check_val({tag, "_pix4"}, got_pix4[(b_pv4 + i) % 64], w);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_data"},  pix_data,    0);
        check_val({tag, "_idx"},   pix_idx,     0);
        check_val({tag, "_pv"},    pix_valid,   0);
        check_val({tag, "_fd"},    frame_done,  0);
        check_val({tag, "_len"},   frame_len,   0);
        check_val({tag, "_err"},   err,         0);
        check_val({tag, "_busy"},  busy,        0);
        check_val({tag, "_data4"}, pix_data4,   0);
        check_val({tag, "_idx4"},  pix_idx4,    0);
        check_val({tag, "_pv4"},   pix_valid4,  0);
        check_val({tag, "_fd4"},   frame_done4, 0);
        check_val({tag, "_len4"},  frame_len4,  0);
        check_val({tag, "_err4"},  err4,        0);
        check_val({tag, "_busy4"}, busy4,       0);
    endtask

    // ---------------- drivers ----------------
    task automatic hold(input logic lvl, input int n);
        din_i = lvl;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_width(input int hi, input int lo);
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_width(40, 22);
        else   send_width(20, 42);
    endtask

    task automatic send_bits(input logic [23:0] d, input int msb, input int lsb);
        for (int i = msb; i >= lsb; i--) send_bit(d[i]);
    endtask

    task automatic send_pixel(input logic [23:0] d, input int idx, input bit push, input bit push4);
        if (push)  exp_q.push_back({8'(idx), d});
        if (push4) exp4_q.push_back({8'(idx), d});
        send_bits(d, 23, 0);
    endtask

    task automatic latch();
        hold(1'b0, 2600);
    endtask

    // ---------------- stimulus ----------------
    logic [23:0] five_pix [5];

    initial begin
        five_pix[0] = 24'h102030;
        five_pix[1] = 24'h405060;
        five_pix[2] = 24'h708090;
        five_pix[3] = 24'hA0B0C0;
        five_pix[4] = 24'hD0E0F0;

        // Reset state, then a single pixel frame.
        reset_ni = 1'b0;
        din_i    = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        check_reset_outputs("por");
        reset_ni = 1'b1;
        hold(1'b0, 2600);

        snap();
        send_pixel(24'hA5C3F0, 0, 1, 1);
        check_val("t1_busy", busy, 1);
        latch();
        score("t1");
        check_val("t1_fd", n_fd - b_fd, 1);
        check_val("t1_len", last_len, 1);
        check_val("t1_err", n_err - b_err, 0);
        check_val("t1_busy_end", busy, 0);
        check_val("t1_hold", pix_data, 24'hA5C3F0);

        // Three pixels with extreme bit patterns.
        snap();
        send_pixel(24'h000001, 0, 1, 1);
        send_pixel(24'h800000, 1, 1, 1);
        send_pixel(24'hFFFFFF, 2, 1, 1);
        latch();
        score("t2");
        check_val("t2_fd", n_fd - b_fd, 1);
        check_val("t2_len", last_len, 3);
        check_val("t2_err", n_err - b_err, 0);

        // Threshold edges: 29 -> 0, 30 -> 1, 7 -> 0, 100 -> 1.
        snap();
        exp_q.push_back({8'd0, 24'h5ABCDE});
        exp4_q.push_back({8'd0, 24'h5ABCDE});
        send_width(29, 42);
        send_width(30, 42);
        send_width(7, 42);
        send_width(100, 42);
        send_bits(24'h5ABCDE, 19, 0);
        latch();
        score("t2b");
        check_val("t2b_len", last_len, 1);
        check_val("t2b_err", n_err - b_err, 0);

        // Release reset with the line high and no leading gap.
        reset_ni = 1'b0;
        din_i    = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        snap();
        send_bits(24'hC0FFEE, 23, 0);
        check_val("t3_pv", n_pv - b_pv, 0);
        check_val("t3_err", n_err - b_err, 0);
        check_val("t3_busy", busy, 0);
        hold(1'b0, 2600);
        check_val("t3_fd", n_fd - b_fd, 0);
        send_pixel(24'h0F0F0F, 0, 1, 1);
        latch();
        score("t3");
        check_val("t3_fd2", n_fd - b_fd, 1);
        check_val("t3_len", last_len, 1);

        // Short glitch in the middle of a pixel.
        snap();
        exp_q.push_back({8'd0, 24'h3C5A96});
        exp4_q.push_back({8'd0, 24'h3C5A96});
        send_bits(24'h3C5A96, 23, 12);
        send_width(5, 30);
        send_bits(24'h3C5A96, 11, 0);
        check_val("t4_err", n_err - b_err, 1);
        check_val("t4_err4", n_err4 - b_err4, 1);
        latch();
        score("t4");
        check_val("t4_fd", n_fd - b_fd, 1);
        check_val("t4_len", last_len, 1);
        check_val("t4_err_end", n_err - b_err, 1);

        // Over-long high pulse abandons the frame.
        snap();
        send_bits(24'hF80000, 23, 19);
        hold(1'b1, 120);
        check_val("t4b_err", n_err - b_err, 1);
        check_val("t4b_busy", busy, 0);
        hold(1'b0, 2600);
        check_val("t4b_fd", n_fd - b_fd, 0);
        score("t4b");

        // Partial pixel at the latch: error and frame end together.
        snap();
        send_bits(24'hFFC000, 23, 14);
        latch();
        check_val("t5_fd", n_fd - b_fd, 1);
        check_val("t5_err", n_err - b_err, 1);
        check_val("t5_both", n_both - b_both, 1);
        check_val("t5_len", last_len, 0);
        score("t5");

        // Five pixels: the NUM_LEDS=4 instance drops the last one.
        snap();
        for (int i = 0; i < 5; i++) send_pixel(five_pix[i], i, 1, i < 4);
        latch();
        score("t6");
        check_val("t6_len", last_len, 5);
        check_val("t6_err", n_err - b_err, 0);
        check_val("t6_fd4", n_fd4 - b_fd4, 1);
        check_val("t6_err4", n_err4 - b_err4, 1);
        check_val("t6_len4", last_len4, 4);

        // Reset in the middle of the second pixel.
        snap();
        send_pixel(24'h13579B, 0, 1, 1);
        send_bits(24'h2468AC, 23, 12);
        reset_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("t7_rst");
        score("t7");
        reset_ni = 1'b1;
        snap();
        hold(1'b0, 100);
        send_bits(24'h2468AC, 23, 0);
        check_val("t7_pv", n_pv - b_pv, 0);
        check_val("t7_err", n_err - b_err, 0);
        hold(1'b0, 2600);
        check_val("t7_fd", n_fd - b_fd, 0);
        check_val("t7_pv4", n_pv4 - b_pv4, 0);
        send_pixel(24'h5A5A5A, 0, 1, 1);
        latch();
        score("t7b");
        check_val("t7b_fd", n_fd - b_fd, 1);
        check_val("t7b_len", last_len, 1);

        check_val("clash", n_clash, 0);
        check_val("clash4", n_clash4, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
